uart_apb_regs: RTL and testbench

APB3 slave register block on the register side of the UART core. It converts bus reads and writes into the core's configuration levels, the TX data word and the start pulse. It captures RX completions, RX data and parity errors into status flags, and raises an interrupt. It is the bus-facing peer of the core's TX/RX control interface.

---
 rtl/uart_apb_regs.sv | 162 ++++++++++++++++
 tb/tb_uart_apb_regs.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_regs.sv
// APB3 register block for the UART core: configuration, TX word and start pulse,
// RX capture with status flags, and a level interrupt. One wait state per transfer.
module uart_apb_regs #(
  parameter int unsigned ADDR_W  = 5,
  parameter logic [4:0]  RST_CFG = 5'b00011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [31:0]       tx_data_o,
  output logic              start_tx_o,
  input  logic              tx_done_i,
  input  logic [31:0]       rx_data_i,
  input  logic              rx_done_i,
  input  logic              parity_error_i,
  output logic [1:0]        data_bit_num_o,
  output logic              parity_en_o,
  output logic              parity_type_o,
  output logic              stop_bit_num_o,
  output logic              irq_o
);

  localparam logic [ADDR_W-1:0] AddrTxData = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] AddrRxData = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] AddrCfg    = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] AddrIer    = ADDR_W'(8'h14);

  localparam int unsigned TxBusy    = 0;
  localparam int unsigned TxDone    = 1;
  localparam int unsigned RxValid   = 2;
  localparam int unsigned ParityErr = 3;
  localparam int unsigned RxOverrun = 4;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] tx_data_q, rx_data_q, prdata_q;
  logic [4:0]  cfg_q, ier_q, status_q, status_d;
  logic        pslverr_q, start_tx_q, irq_q;

  logic [ADDR_W-1:0] addr_word;
  logic        access, wr_access, rd_access;
  logic        sel_tx, sel_rx, sel_cfg, sel_ctrl, sel_status, sel_ier, mapped;
  logic        err, wr_commit, start, rx_read;
  logic [31:0] rdata;

  // Byte offset within a word is ignored; word access only.
  logic unused_paddr;
  assign unused_paddr = ^paddr[1:0];
  assign addr_word    = {paddr[ADDR_W-1:2], 2'b00};

  assign access    = (state_q == StIdle) & psel & penable;
  assign wr_access = access & pwrite;
  assign rd_access = access & ~pwrite;

  assign sel_tx     = (addr_word == AddrTxData);
  assign sel_rx     = (addr_word == AddrRxData);
  assign sel_cfg    = (addr_word == AddrCfg);
  assign sel_ctrl   = (addr_word == AddrCtrl);
  assign sel_status = (addr_word == AddrStatus);
  assign sel_ier    = (addr_word == AddrIer);
  assign mapped     = sel_tx | sel_rx | sel_cfg | sel_ctrl | sel_status | sel_ier;

  assign err = access & (~mapped
                         | (pwrite & sel_rx)
                         | (pwrite & sel_ctrl & pwdata[0] & status_q[TxBusy]));

  assign wr_commit = wr_access & ~err;
  assign start     = wr_commit & sel_ctrl & pwdata[0];
  assign rx_read   = rd_access & sel_rx;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (access) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!err) begin
      if (sel_tx)     rdata = tx_data_q;
      if (sel_rx)     rdata = rx_data_q;
      if (sel_cfg)    rdata = {27'd0, cfg_q};
      if (sel_status) rdata = {27'd0, status_q};
      if (sel_ier)    rdata = {27'd0, ier_q};
    end
  end

  // Clears are applied first so that a same-cycle hardware set wins.
  always_comb begin
    status_d = status_q;
    if (wr_commit && sel_status) begin
      if (pwdata[TxDone])    status_d[TxDone]    = 1'b0;
      if (pwdata[ParityErr]) status_d[ParityErr] = 1'b0;
      if (pwdata[RxOverrun]) status_d[RxOverrun] = 1'b0;
    end
    if (rx_read) status_d[RxValid] = 1'b0;
    if (tx_done_i) begin
      status_d[TxBusy] = 1'b0;
      status_d[TxDone] = 1'b1;
    end
    if (start) status_d[TxBusy] = 1'b1;
    if (rx_done_i) begin
      status_d[RxValid] = 1'b1;
      if (parity_error_i) status_d[ParityErr] = 1'b1;
      // A read consuming the old word in the same cycle is not an overrun.
      if (status_q[RxValid] && !rx_read) status_d[RxOverrun] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_data_q  <= '0;
      rx_data_q  <= '0;
      prdata_q   <= '0;
      cfg_q      <= RST_CFG;
      ier_q      <= '0;
      status_q   <= '0;
      pslverr_q  <= 1'b0;
      start_tx_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      start_tx_q <= start;
      irq_q      <= |(status_q & ier_q);
      if (access) begin
        prdata_q  <= rdata;
        pslverr_q <= err;
      end
      if (wr_commit && sel_tx)  tx_data_q <= pwdata;
      if (wr_commit && sel_cfg) cfg_q     <= pwdata[4:0];
      if (wr_commit && sel_ier) ier_q     <= pwdata[4:0];
      if (rx_done_i)            rx_data_q <= rx_data_i;
    end
  end

  assign pready         = (state_q == StResp);
  assign prdata         = prdata_q;
  assign pslverr        = pslverr_q;
  assign tx_data_o      = tx_data_q;
  assign start_tx_o     = start_tx_q;
  assign data_bit_num_o = cfg_q[1:0];
  assign parity_en_o    = cfg_q[2];
  assign parity_type_o  = cfg_q[3];
  assign stop_bit_num_o = cfg_q[4];
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: directed register-map scenarios followed by random bus and
// core events, all checked against a flag-level reference model.
module tb_uart_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [31:0] tx_data_o;
  logic        start_tx_o, tx_done_i;
  logic [31:0] rx_data_i;
  logic        rx_done_i, parity_error_i;
  logic [1:0]  data_bit_num_o;
  logic        parity_en_o, parity_type_o, stop_bit_num_o, irq_o;

  uart_apb_regs #(.ADDR_W(5), .RST_CFG(5'b00011)) dut (
    .clk            (clk),
    .rst            (rst),
    .paddr          (paddr),
    .psel           (psel),
    .penable        (penable),
    .pwrite         (pwrite),
    .pwdata         (pwdata),
    .prdata         (prdata),
    .pready         (pready),
    .pslverr        (pslverr),
    .tx_data_o      (tx_data_o),
    .start_tx_o     (start_tx_o),
    .tx_done_i      (tx_done_i),
    .rx_data_i      (rx_data_i),
    .rx_done_i      (rx_done_i),
    .parity_error_i (parity_error_i),
    .data_bit_num_o (data_bit_num_o),
    .parity_en_o    (parity_en_o),
    .parity_type_o  (parity_type_o),
    .stop_bit_num_o (stop_bit_num_o),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int start_cnt = 0;

  always @(negedge clk) if (start_tx_o === 1'b1) start_cnt++;

  // Reference model: registers and individual status flags.
  logic [31:0] m_tx, m_rx;
  logic [4:0]  m_cfg, m_ier;
  bit          m_busy, m_done, m_valid, m_perr, m_ovr;
  int          m_starts = 0;

  function automatic logic [4:0] m_status();
    return {m_ovr, m_perr, m_valid, m_done, m_busy};
  endfunction

  task automatic model_reset();
    m_tx = '0; m_rx = '0; m_cfg = 5'h03; m_ier = '0;
    m_busy = 0; m_done = 0; m_valid = 0; m_perr = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit acc, input bit wr, input logic [4:0] addr,
                            input logic [31:0] wd, input bit txd, input bit rxd,
                            input logic [31:0] rxw, input bit pe,
                            output logic [31:0] rd, output bit err);
    int word;
    bit start, rx_read, old_valid;
    word = int'(addr[4:2]);
    start = 0; rx_read = 0; old_valid = m_valid; rd = '0; err = 0;
    if (acc) begin
      case (word)
        0: rd = m_tx;
        1: begin rd = m_rx; err = wr; rx_read = !wr; end
        2: rd = {27'd0, m_cfg};
        3: err = wr && wd[0] && m_busy;
        4: rd = {27'd0, m_status()};
        5: rd = {27'd0, m_ier};
        default: err = 1;
      endcase
      if (err) rd = '0;
      if (wr && !err) begin
        case (word)
          0: m_tx = wd;
          2: m_cfg = wd[4:0];
          3: start = wd[0];
          4: begin
            if (wd[1]) m_done = 0;
            if (wd[3]) m_perr = 0;
            if (wd[4]) m_ovr = 0;
          end
          5: m_ier = wd[4:0];
          default: ;
        endcase
      end
      if (rx_read) m_valid = 0;
    end
    if (txd) begin m_busy = 0; m_done = 1; end
    if (start) begin m_busy = 1; m_starts++; end
    if (rxd) begin
      m_rx = rxw;
      m_valid = 1;
      if (pe) m_perr = 1;
      if (old_valid && !rx_read) m_ovr = 1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full APB transfer; optional core events are driven during the access cycle.
  task automatic apb_xfer(input bit wr, input logic [4:0] addr, input logic [31:0] wd,
                          input bit txd, input bit rxd, input logic [31:0] rxw, input bit pe,
                          output logic [31:0] rd, output logic err);
    int waits;
    logic [31:0] exp_rd;
    bit exp_err;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    check_eq("setup_pready", 32'(pready), 32'd0);
    penable = 1; tx_done_i = txd; rx_done_i = rxd; rx_data_i = rxw; parity_error_i = pe;
    model_step(1, wr, addr, wd, txd, rxd, rxw, pe, exp_rd, exp_err);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
      tx_done_i = 0; rx_done_i = 0; parity_error_i = 0;
    end while (pready !== 1'b1 && waits < 8);
    check_eq("pready_latency", 32'(waits), 32'd1);
    rd = prdata; err = pslverr;
    check_eq("pslverr", 32'(err), 32'(exp_err));
    if (!wr) check_eq("prdata", rd, exp_rd);
    psel = 0; penable = 0;
  endtask

  task automatic hw_pulse(input bit txd, input bit rxd, input logic [31:0] rxw, input bit pe);
    logic [31:0] d_rd;
    bit d_err;
    @(negedge clk);
    tx_done_i = txd; rx_done_i = rxd; rx_data_i = rxw; parity_error_i = pe;
    model_step(0, 0, 5'd0, 32'd0, txd, rxd, rxw, pe, d_rd, d_err);
    @(negedge clk);
    tx_done_i = 0; rx_done_i = 0; parity_error_i = 0;
  endtask

  task automatic check_state();
    @(negedge clk);
    check_eq("idle_pready", 32'(pready), 32'd0);
    check_eq("irq", 32'(irq_o), 32'(|(m_status() & m_ier)));
    check_eq("tx_data_o", tx_data_o, m_tx);
    check_eq("cfg_out", 32'({stop_bit_num_o, parity_type_o, parity_en_o, data_bit_num_o}),
             32'(m_cfg));
    check_eq("start_count", 32'(start_cnt), 32'(m_starts));
    check_eq("start_low", 32'(start_tx_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_v;
    logic        err_v;
    int          op;
    logic [4:0]  a;
    logic [31:0] d, w;
    bit          txd, rxd, pe, combo;

    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    tx_done_i = 0; rx_done_i = 0; rx_data_i = '0; parity_error_i = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
    check_state();

    // Reset values
    apb_xfer(0, 5'h08, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("reset_cfg", rd_v, 32'h3);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("reset_status", rd_v, 32'h0);

    // TX start, busy start, done and W1C
    apb_xfer(1, 5'h00, 32'hA5, 0, 0, 0, 0, rd_v, err_v);
    apb_xfer(1, 5'h0C, 32'h1, 0, 0, 0, 0, rd_v, err_v);
    check_state();
    check_eq("tx_word", tx_data_o, 32'hA5);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("busy_status", rd_v, 32'h1);
    apb_xfer(1, 5'h0C, 32'h1, 0, 0, 0, 0, rd_v, err_v);
    check_eq("busy_start_err", 32'(err_v), 32'd1);
    check_state();
    hw_pulse(1, 0, 0, 0);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("done_status", rd_v, 32'h2);
    apb_xfer(1, 5'h10, 32'h2, 0, 0, 0, 0, rd_v, err_v);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("w1c_status", rd_v, 32'h0);

    // RX overrun
    hw_pulse(0, 1, 32'h55, 0);
    hw_pulse(0, 1, 32'h66, 0);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("ovr_status", rd_v, 32'h14);
    apb_xfer(0, 5'h04, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("ovr_data", rd_v, 32'h66);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("ovr_after_read", rd_v, 32'h10);

    // Parity interrupt with one-cycle lag, then W1C racing a new parity error
    apb_xfer(1, 5'h14, 32'h08, 0, 0, 0, 0, rd_v, err_v);
    check_state();
    hw_pulse(0, 1, 32'h12, 1);
    check_eq("irq_lag", 32'(irq_o), 32'd0);
    check_state();
    check_eq("irq_set", 32'(irq_o), 32'd1);
    apb_xfer(1, 5'h10, 32'h08, 0, 1, 32'h34, 1, rd_v, err_v);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("perr_set_wins", 32'(rd_v[3]), 32'd1);

    // RX read racing a new word
    apb_xfer(1, 5'h10, 32'h1A, 0, 0, 0, 0, rd_v, err_v);
    apb_xfer(0, 5'h04, 0, 0, 1, 32'h77, 0, rd_v, err_v);
    check_eq("race_old_word", rd_v, 32'h34);
    apb_xfer(0, 5'h10, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("race_status", rd_v & 32'h14, 32'h04);

    // Error responses
    apb_xfer(0, 5'h18, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("unmapped_err", 32'(err_v), 32'd1);
    check_eq("unmapped_data", rd_v, 32'h0);
    apb_xfer(1, 5'h04, 32'hDEAD, 0, 0, 0, 0, rd_v, err_v);
    apb_xfer(0, 5'h04, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("rx_ro", rd_v, 32'h77);

    // Setup phase alone must not complete or write anything
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 5'h08; pwdata = 32'h1F;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("no_enable_pready", 32'(pready), 32'd0);
    end
    psel = 0;
    check_state();

    // Reset during the response cycle of a CFG write
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 5'h08; pwdata = 32'h1C;
    @(negedge clk);
    penable = 1;
    @(negedge clk);
    rst = 1; psel = 0; penable = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    check_state();
    apb_xfer(0, 5'h08, 0, 0, 0, 0, 0, rd_v, err_v);
    check_eq("cfg_after_rst", rd_v, 32'h3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 9));
      a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      d = $urandom;
      w = $urandom;
      txd = ($urandom_range(0, 5) == 0);
      rxd = ($urandom_range(0, 3) == 0);
      pe = 1'($urandom_range(0, 1));
      combo = ($urandom_range(0, 3) == 0);
      if (op <= 3) begin
        apb_xfer(1, a, d, txd && combo, rxd && combo, w, pe, rd_v, err_v);
      end else if (op <= 6) begin
        apb_xfer(0, a, 0, txd && combo, rxd && combo, w, pe, rd_v, err_v);
      end else if (op == 7) begin
        hw_pulse(1, 0, 0, 0);
      end else begin
        hw_pulse(0, 1, w, pe);
      end
      check_state();
    end

    for (int k = 0; k < 6; k++) begin
      apb_xfer(0, 5'(k * 4), 0, 0, 0, 0, 0, rd_v, err_v);
    end
    check_state();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
